// File: rtl/rf_read_port_arbiter_pkg.sv
// Shared constants for the register-file read-port arbiter slice.
// Requester indices map pipeline clients onto arbiter request bits.
package rf_read_port_arbiter_pkg;

    localparam int unsigned RF_ADDR_W       = 5;
    localparam int unsigned RF_DATA_W       = 32;
    localparam int unsigned RF_NUM_READ_REQ = 4;

    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_DEC_A = 1;
    localparam int unsigned REQ_DEC_B = 2;
    localparam int unsigned REQ_DBG   = 3;

    // Width of an encoded requester index; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_read_port_arbiter_picker.sv
// Combinational round-robin picker: first set request searching upward
// from last_gnt+1 with wrap-around, yielding a one-hot grant and its index.
module rr_priority_picker
    import rf_read_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = RF_NUM_READ_REQ,
    localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    input  logic [IDX_W-1:0]   i_last_gnt,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_gnt_vld
);

    int unsigned w_last;

    assign w_last = 32'(i_last_gnt);

    // Outer loop walks priority order; the found flag keeps the grant one-hot.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        if (i_en) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (!o_gnt_vld && i_req[i] && (i == ((w_last + k) % NUM_REQ))) begin
                        o_gnt[i]  = 1'b1;
                        o_gnt_idx = IDX_W'(i);
                        o_gnt_vld = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rf_read_port_arbiter.sv
// Shares one 32:1 register-file read mux between NUM_REQ clients: grant and
// register the winner's address, then capture mux data one cycle later.
module rf_read_port_arbiter
    import rf_read_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = RF_NUM_READ_REQ,
    parameter int unsigned ADDR_W  = RF_ADDR_W,
    parameter int unsigned DATA_W  = RF_DATA_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         mux_sel,
    input  logic [DATA_W-1:0]         mux_data,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rvalid
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_gnt_vld;
    logic [ADDR_W-1:0]  w_sel_addr;

    logic [IDX_W-1:0]   r_last_gnt;
    logic [ADDR_W-1:0]  r_mux_sel;
    logic [NUM_REQ-1:0] r_inflight;
    logic [DATA_W-1:0]  r_rdata;
    logic [NUM_REQ-1:0] r_rvalid;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req      (req),
        .i_en       (en),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt),
        .o_gnt_idx  (w_gnt_idx),
        .o_gnt_vld  (w_gnt_vld)
    );

    // One-hot AND-OR select of the winner's address slice.
    always_comb begin
        w_sel_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = w_sel_addr | addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last_gnt <= IDX_W'(NUM_REQ - 1);
            r_mux_sel  <= '0;
            r_inflight <= '0;
        end else if (w_gnt_vld) begin
            r_last_gnt <= w_gnt_idx;
            r_mux_sel  <= w_sel_addr;
            r_inflight <= w_gnt;
        end else begin
            r_inflight <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            if (|r_inflight) begin
                r_rdata <= mux_data;
            end
            r_rvalid <= r_inflight;
        end
    end

    assign gnt     = w_gnt;
    assign mux_sel = r_mux_sel;
    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Directed and randomized bench for rf_read_port_arbiter against a
// transaction-level model of arbitration and read returns.
module tb_rf_read_port_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          CLK;
    logic          RST;
    logic          en;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]  gnt;
    logic [AW-1:0] mux_sel;
    logic [DW-1:0] mux_data;
    logic [DW-1:0] rdata;
    logic [N-1:0]  rvalid;

    logic [AW-1:0] a_arr [N];

    rf_read_port_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .en       (en),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .mux_sel  (mux_sel),
        .mux_data (mux_data),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign addr = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};

    // Register k holds 10..19, 110..119, 210..219, 310, 311.
    function automatic logic [31:0] imodel(input logic [4:0] k);
        int unsigned kk;
        kk = 32'(k);
        return 32'((kk / 10) * 100 + 10 + (kk % 10));
    endfunction

    always_comb mux_data = imodel(mux_sel);

    typedef struct {
        int unsigned due;
        int          idx;
        logic [31:0] data;
    } ret_t;

    ret_t          q[$];
    int unsigned   cyc;
    int            m_last;
    logic [4:0]    m_sel;
    logic [31:0]   m_rdata;
    int            last_w;
    logic [N-1:0]  g_obs;
    int unsigned   nchk;
    int unsigned   nfail;

    function automatic int pick(input logic [N-1:0] r, input logic e, input int last);
        int i;
        if (!e) return -1;
        for (int k = 1; k <= int'(N); k++) begin
            i = (last + k) % int'(N);
            if (r[i[1:0]]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last  = int'(N) - 1;
        m_sel   = '0;
        m_rdata = '0;
    endtask

    // Entered just after a rising edge; asserts reset away from any edge.
    task automatic do_reset();
        RST = 1'b0;
        #2;
        model_reset();
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mux_sel", 32'(mux_sel), 32'd0);
        #1;
        RST = 1'b1;
    endtask

    // One clock cycle: check outputs and grant mid-cycle, then advance.
    task automatic step();
        logic [N-1:0] ev;
        logic [N-1:0] eg;
        logic [4:0]   a;
        int           w;
        @(negedge CLK);
        ev = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev      = N'(1) << q[0].idx;
            m_rdata = q[0].data;
            void'(q.pop_front());
        end
        chk("rvalid", 32'(rvalid), 32'(ev));
        chk("rdata", rdata, m_rdata);
        chk("mux_sel", 32'(mux_sel), 32'(m_sel));
        w     = pick(req, en, m_last);
        eg    = (w >= 0) ? (N'(1) << w) : '0;
        g_obs = gnt;
        chk("gnt", 32'(gnt), 32'(eg));
        last_w = w;
        if (w >= 0) begin
            a = a_arr[w[1:0]];
            q.push_back('{due: cyc + 2, idx: w, data: imodel(a)});
            m_sel  = a;
            m_last = w;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    initial begin
        nchk  = 0;
        nfail = 0;
        cyc   = 0;
        last_w = -1;
        RST = 1'b0;
        en  = 1'b0;
        req = '0;
        for (int i = 0; i < int'(N); i++) a_arr[i] = '0;
        model_reset();
        @(posedge CLK);
        #1;
        do_reset();
        en = 1'b1;
        step();
        step();

        // Accepted read discarded by a reset while in flight.
        a_arr[0] = 5'd3;
        req = 4'b0001;
        step();
        chk("mf_gnt", 32'(g_obs), 32'd1);
        req = '0;
        do_reset();
        step();
        step();
        step();

        // Single read latency.
        req = 4'b0001;
        a_arr[0] = 5'd3;
        step();
        chk("single_gnt", 32'(g_obs), 32'd1);
        req = '0;
        chk("single_sel_n1", 32'(mux_sel), 32'd3);
        step();
        chk("single_rdata_n2", rdata, 32'd13);
        chk("single_rvalid_n2", 32'(rvalid), 32'd1);
        step();

        // All four requesting: rotation 0,1,2,3,0.
        do_reset();
        a_arr[0] = 5'd0;
        a_arr[1] = 5'd17;
        a_arr[2] = 5'd30;
        a_arr[3] = 5'd31;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            step();
            chk("rot_gnt", 32'(g_obs), 32'd1 << (t % 4));
        end
        req = '0;
        step();
        step();
        step();

        // One requester held high with stepping address.
        do_reset();
        req = 4'b0100;
        for (int a = 1; a <= 3; a++) begin
            a_arr[2] = 5'(a);
            step();
            chk("hold_gnt", 32'(g_obs), 32'b0100);
        end
        req = '0;
        step();
        step();
        step();

        // Enable dropped with requests pending, then resumed.
        do_reset();
        a_arr[1] = 5'd7;
        a_arr[3] = 5'd9;
        req = 4'b0010;
        step();
        req = 4'b1010;
        en  = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("en_off_gnt", 32'(g_obs), 32'd0);
        end
        chk("en_off_sel", 32'(mux_sel), 32'd7);
        en = 1'b1;
        step();
        chk("en_resume_gnt", 32'(g_obs), 32'b1000);
        req = '0;
        step();
        step();
        step();

        // Wrap-around from requester 3; addr changed after acceptance.
        do_reset();
        a_arr[3] = 5'd2;
        req = 4'b1000;
        step();
        a_arr[0] = 5'd5;
        a_arr[1] = 5'd17;
        req = 4'b0011;
        step();
        chk("wrap_gnt0", 32'(g_obs), 32'b0001);
        req = 4'b0010;
        step();
        chk("wrap_gnt1", 32'(g_obs), 32'b0010);
        a_arr[1] = 5'd9;
        req = '0;
        step();
        chk("wrap_rdata", rdata, 32'd117);
        chk("wrap_rvalid", 32'(rvalid), 32'b0010);
        step();
        step();

        // Randomized traffic obeying the request handshake.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            step();
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < int'(N); i++) begin
                if (i == last_w) begin
                    req[i[1:0]]   = ($urandom_range(0, 1) == 1);
                    a_arr[i[1:0]] = 5'($urandom_range(0, 31));
                end else if (!req[i[1:0]] && $urandom_range(0, 2) == 0) begin
                    req[i[1:0]]   = 1'b1;
                    a_arr[i[1:0]] = 5'($urandom_range(0, 31));
                end
            end
        end
        req = '0;
        step();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
